// File: rtl/tick_sched_pkg.sv
// Shared op-codes, FSM state type and period limits for the tick scheduler.
package tick_sched_pkg;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_SYNC  = 2'd3;

    localparam int MIN_PERIOD = 2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_t;

endpackage

// File: rtl/tick_sched_chan.sv
// One tick channel: period/counter/mode registers and registered tick/done pulses.
module tick_chan #(
    parameter int PW             = 16,
    parameter int DEFAULT_PERIOD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          start,
    input  logic          stop,
    input  logic          sync,
    input  logic [PW-1:0] period,
    input  logic          oneshot,
    output logic          tick,
    output logic          done,
    output logic          running
);

    logic [PW-1:0] p_q, p_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          os_q, os_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    always_comb begin
        p_d    = p_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        os_d   = os_q;
        tick_d = 1'b0;
        done_d = 1'b0;

        if (run_q) begin
            if (cnt_q == p_q - 1'b1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (os_q) begin
                    done_d = 1'b1;
                    run_d  = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A command on this edge overrides the wrap: pulses dropped, counter restarts.
        if (load || start || stop || sync) begin
            tick_d = 1'b0;
            done_d = 1'b0;
            cnt_d  = '0;
            run_d  = run_q;
            if (load) begin
                p_d = period;
            end
            if (start) begin
                run_d = 1'b1;
                os_d  = oneshot;
            end
            if (stop) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q    <= PW'(DEFAULT_PERIOD);
            cnt_q  <= '0;
            run_q  <= 1'b0;
            os_q   <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            os_q   <= os_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign tick    = tick_q;
    assign done    = done_q;
    assign running = run_q;

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick scheduler: two-state command FSM, command latch/decode and NUM_CH tick channels.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int PW             = 16,
    parameter int DEFAULT_PERIOD = 2,
    localparam int CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              org_clk,
    input  logic              sys_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [PW-1:0]     cfg_period,
    input  logic              cfg_oneshot,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] running
);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [PW-1:0] period_q, period_d;
    logic          oneshot_q, oneshot_d;
    logic          cfg_err_q, cfg_err_d;

    logic              ch_ok;
    logic              clamp;
    logic [PW-1:0]     period_c;
    logic [NUM_CH-1:0] load_v, start_v, stop_v, sync_v;

    assign ch_ok    = ({1'b0, ch_q} < (CW+1)'(NUM_CH));
    assign clamp    = (period_q < PW'(MIN_PERIOD));
    assign period_c = clamp ? PW'(MIN_PERIOD) : period_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ch_d      = ch_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        cfg_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    op_d      = cfg_op;
                    ch_d      = cfg_ch;
                    period_d  = cfg_period;
                    oneshot_d = cfg_oneshot;
                    state_d   = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                if (op_q != OP_SYNC) begin
                    cfg_err_d = !ch_ok || ((op_q == OP_LOAD) && clamp);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are live only during APPLY, so commands execute on the edge that leaves it.
    always_comb begin
        load_v  = '0;
        start_v = '0;
        stop_v  = '0;
        sync_v  = '0;
        if (state_q == S_APPLY) begin
            if (op_q == OP_SYNC) begin
                sync_v = '1;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_ok && (ch_q == CW'(i))) begin
                        load_v[i]  = (op_q == OP_LOAD);
                        start_v[i] = (op_q == OP_START);
                        stop_v[i]  = (op_q == OP_STOP);
                    end
                end
            end
        end
    end

    always_ff @(posedge org_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            ch_q      <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ch_q      <= ch_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign cfg_err   = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        tick_chan #(
            .PW             (PW),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk     (org_clk),
            .rst     (sys_rst),
            .load    (load_v[g]),
            .start   (start_v[g]),
            .stop    (stop_v[g]),
            .sync    (sync_v[g]),
            .period  (period_c),
            .oneshot (oneshot_q),
            .tick    (tick[g]),
            .done    (done[g]),
            .running (running[g])
        );
    end

endmodule
